// File: rtl/cnn_layer_accel_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_accel_seq_gen
// Purpose  : Generates the AWE sequence-word stream {RM, RST, P, SEQ} for
//            cnn_layer_accel_octo. It walks rows x columns x group words,
//            applies a configurable SEQ stride, and stalls on backpressure.
// Ports    : clk, rst (async, active-high)
//            start             - one-cycle request, honoured only in IDLE
//            num_out_cols_cfg  - output columns minus 1
//            num_out_rows_cfg  - row passes minus 1
//            group_len_cfg     - words per column group minus 1
//            seq_stride_cfg    - SEQ increment between words of a group
//            dataout/_valid/_tag, dataout_rdy - word stream with handshake
//            busy              - high while streaming
//            done              - one-cycle pulse after the final transfer
// Revision : 1.0 - initial release
// ============================================================================
module cnn_layer_accel_seq_gen #(
    parameter int C_SEQ_WIDTH = 10,
    parameter int C_COL_WIDTH = 10,
    parameter int C_ROW_WIDTH = 10,
    parameter int C_GRP_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [C_COL_WIDTH-1:0]   num_out_cols_cfg,
    input  logic [C_ROW_WIDTH-1:0]   num_out_rows_cfg,
    input  logic [C_GRP_WIDTH-1:0]   group_len_cfg,
    input  logic [C_SEQ_WIDTH-1:0]   seq_stride_cfg,
    output logic [C_SEQ_WIDTH+2:0]   dataout,
    output logic                     dataout_valid,
    output logic                     dataout_tag,
    input  logic                     dataout_rdy,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [C_COL_WIDTH-1:0] r_cols;
    logic [C_ROW_WIDTH-1:0] r_rows;
    logic [C_GRP_WIDTH-1:0] r_glen;
    logic [C_SEQ_WIDTH-1:0] r_stride;
    logic [C_ROW_WIDTH-1:0] r_row;
    logic [C_COL_WIDTH-1:0] r_col;
    logic [C_GRP_WIDTH-1:0] r_k;
    logic [C_SEQ_WIDTH-1:0] r_acc;

    logic [C_ROW_WIDTH-1:0] w_row_nxt;
    logic [C_COL_WIDTH-1:0] w_col_nxt;
    logic [C_GRP_WIDTH-1:0] w_k_nxt;
    logic [C_SEQ_WIDTH-1:0] w_acc_nxt;
    logic                   w_last;
    logic [C_SEQ_WIDTH+2:0] w_word_nxt;
    logic                   w_xfer;

    // Word layout: RM marks the last word of a group, RST the first; P is a
    // checkerboard parity of (column, row) carried only on the first word.
    function automatic logic [C_SEQ_WIDTH+2:0] make_word(
        input logic [C_GRP_WIDTH-1:0] k,
        input logic [C_GRP_WIDTH-1:0] glen,
        input logic                   col_lsb,
        input logic                   row_lsb,
        input logic [C_SEQ_WIDTH-1:0] seq
    );
        logic first;
        first = (k == '0);
        return {(k == glen), first, first & (col_lsb ^ row_lsb), seq};
    endfunction

    assign w_xfer = dataout_valid & dataout_rdy;

    // Counter advance for one accepted word. SEQ is accumulated rather than
    // multiplied: +stride inside a group, reloaded with the new column index
    // at a group boundary. Wraparound at 2^C_SEQ_WIDTH is intentional.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        w_k_nxt   = r_k;
        w_acc_nxt = r_acc;
        w_last    = 1'b0;
        if (r_k < r_glen) begin
            w_k_nxt   = r_k + 1'b1;
            w_acc_nxt = r_acc + r_stride;
        end else begin
            w_k_nxt = '0;
            if (r_col < r_cols) begin
                w_col_nxt = r_col + 1'b1;
                w_acc_nxt = C_SEQ_WIDTH'(w_col_nxt);
            end else begin
                w_col_nxt = '0;
                w_acc_nxt = '0;
                if (r_row < r_rows) begin
                    w_row_nxt = r_row + 1'b1;
                end else begin
                    w_last = 1'b1;
                end
            end
        end
        w_word_nxt = make_word(w_k_nxt, r_glen, w_col_nxt[0], w_row_nxt[0], w_acc_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cols        <= '0;
            r_rows        <= '0;
            r_glen        <= '0;
            r_stride      <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_k           <= '0;
            r_acc         <= '0;
            dataout       <= '0;
            dataout_valid <= 1'b0;
            dataout_tag   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_cols        <= num_out_cols_cfg;
                        r_rows        <= num_out_rows_cfg;
                        r_glen        <= group_len_cfg;
                        r_stride      <= seq_stride_cfg;
                        r_row         <= '0;
                        r_col         <= '0;
                        r_k           <= '0;
                        r_acc         <= '0;
                        // Word (0,0,0): SEQ=0, RST=1, P=0, RM only for 1-word groups.
                        dataout       <= {(group_len_cfg == '0), 1'b1, 1'b0, {C_SEQ_WIDTH{1'b0}}};
                        dataout_valid <= 1'b1;
                        dataout_tag   <= 1'b1;
                        busy          <= 1'b1;
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Without a transfer everything holds, which gives the stall.
                    if (w_xfer) begin
                        if (w_last) begin
                            dataout       <= '0;
                            dataout_valid <= 1'b0;
                            dataout_tag   <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_row   <= w_row_nxt;
                            r_col   <= w_col_nxt;
                            r_k     <= w_k_nxt;
                            r_acc   <= w_acc_nxt;
                            dataout <= w_word_nxt;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_accel_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_layer_accel_seq_gen
// Purpose  : Self-checking bench for cnn_layer_accel_seq_gen. Expected words
//            come from a closed-form model (SEQ = c + k*stride mod 1024).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_layer_accel_seq_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  cols_cfg = '0;
    logic [9:0]  rows_cfg = '0;
    logic [3:0]  glen_cfg = '0;
    logic [9:0]  stride_cfg = '0;
    logic [12:0] dataout;
    logic        valid;
    logic        tag;
    logic        rdy = 1'b1;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [12:0] exp_q[$];
    logic [12:0] got[$];

    cnn_layer_accel_seq_gen dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .num_out_cols_cfg (cols_cfg),
        .num_out_rows_cfg (rows_cfg),
        .group_len_cfg    (glen_cfg),
        .seq_stride_cfg   (stride_cfg),
        .dataout          (dataout),
        .dataout_valid    (valid),
        .dataout_tag      (tag),
        .dataout_rdy      (rdy),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] exp_word(int r, int c, int k, int glen, int stride);
        int seq;
        seq = (c + k * stride) % 1024;
        return {(k == glen), (k == 0), ((k == 0) && (((c + r) % 2) == 1)), seq[9:0]};
    endfunction

    // rdy_mode: 0 always ready, 1 three-cycle stall on word 7, 2 random.
    task automatic run_stream(input int cols, input int rows, input int glen,
                              input int stride, input int rdy_mode, input bit perturb);
        int total, idx, busy_cnt, stall_cnt, stall7;
        bit prev_hold, seen_done;
        logic [12:0] prev;
        exp_q.delete();
        got.delete();
        for (int r = 0; r <= rows; r++)
            for (int c = 0; c <= cols; c++)
                for (int k = 0; k <= glen; k++)
                    exp_q.push_back(exp_word(r, c, k, glen, stride));
        total = exp_q.size();
        @(negedge clk);
        cols_cfg = 10'(cols); rows_cfg = 10'(rows); glen_cfg = 4'(glen); stride_cfg = 10'(stride);
        start = 1'b1; rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; busy_cnt = 0; stall_cnt = 0; stall7 = 0; prev_hold = 0; seen_done = 0; prev = '0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (done) begin
                seen_done = 1;
                break;
            end
            n_checks++;
            if (tag !== valid || busy !== valid) begin
                n_fail++;
                $display("FAIL run_flags: tag=%b busy=%b required both equal valid=%b", tag, busy, valid);
            end
            if (valid) busy_cnt++;
            if (prev_hold) begin
                n_checks++;
                if (dataout !== prev) begin
                    n_fail++;
                    $display("FAIL stall_hold: dataout=%h required %h", dataout, prev);
                end
            end
            if (valid) begin
                n_checks++;
                if (idx >= total) begin
                    n_fail++;
                    $display("FAIL overrun: word %0d presented, only %0d expected", idx, total);
                end else if (dataout !== exp_q[idx]) begin
                    n_fail++;
                    $display("FAIL word[%0d]: dataout=%h required %h", idx, dataout, exp_q[idx]);
                end
            end
            case (rdy_mode)
                1: if (idx == 7 && stall7 < 3) begin rdy = 1'b0; stall7++; end else rdy = 1'b1;
                2: rdy = 1'($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            if (perturb && cyc == 10) begin
                start = 1'b1;
                cols_cfg = 10'($urandom); rows_cfg = 10'($urandom);
                glen_cfg = 4'($urandom); stride_cfg = 10'($urandom);
            end else begin
                start = 1'b0;
            end
            if (valid && !rdy) stall_cnt++;
            prev_hold = valid && !rdy;
            prev = dataout;
            if (valid && rdy) begin
                got.push_back(dataout);
                idx++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        rdy = 1'b1;
        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL done_timeout: no done pulse after %0d transfers, required %0d", idx, total);
        end else if (idx != total || valid !== 1'b0 || busy !== 1'b0 || dataout !== 13'h0) begin
            n_fail++;
            $display("FAIL end_state: xfers=%0d valid=%b busy=%b dataout=%h required %0d,0,0,0",
                     idx, valid, busy, dataout, total);
        end
        n_checks++;
        if (busy_cnt != total + stall_cnt) begin
            n_fail++;
            $display("FAIL busy_cycles: %0d required %0d", busy_cnt, total + stall_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({dataout, valid, tag, busy, done} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_state: dataout=%h valid=%b tag=%b busy=%b done=%b required all 0",
                     dataout, valid, tag, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_stream(7, 0, 4, 100, 0, 0);
        n_checks++;
        if (got[4] !== {1'b1, 1'b0, 1'b0, 10'd400} || got[15] !== {1'b0, 1'b1, 1'b1, 10'd3}) begin
            n_fail++;
            $display("FAIL basic_fields: w4=%h w15=%h required %h %h",
                     got[4], got[15], {1'b1, 1'b0, 1'b0, 10'd400}, {1'b0, 1'b1, 1'b1, 10'd3});
        end
    endtask

    task automatic test_backpressure();
        run_stream(7, 0, 4, 100, 1, 0);
        n_checks++;
        if (got.size() != 40 || got[7] !== {1'b0, 1'b0, 1'b0, 10'd201}) begin
            n_fail++;
            $display("FAIL backpressure: xfers=%0d w7=%h required 40 and %h",
                     got.size(), got[7], {1'b0, 1'b0, 1'b0, 10'd201});
        end
    endtask

    task automatic test_wrap();
        run_stream(0, 0, 4, 512, 0, 0);
        n_checks++;
        if (got[1][9:0] !== 10'd512 || got[2][9:0] !== 10'd0 || got[3][9:0] !== 10'd512) begin
            n_fail++;
            $display("FAIL wrap_seq: %0d %0d %0d required 512 0 512", got[1][9:0], got[2][9:0], got[3][9:0]);
        end
        run_stream(3, 0, 0, 77, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got[i][12:11] !== 2'b11 || got[i][9:0] !== 10'(i)) begin
                n_fail++;
                $display("FAIL single_word[%0d]: got %h required RM=RST=1 SEQ=%0d", i, got[i], i);
            end
        end
    endtask

    task automatic test_multirow();
        logic [3:0] pv;
        run_stream(1, 1, 1, 10, 0, 0);
        pv = {got[6][10], got[4][10], got[2][10], got[0][10]};
        n_checks++;
        if (got.size() != 8 || pv !== 4'b0110) begin
            n_fail++;
            $display("FAIL multirow_p: xfers=%0d P(w6..w0)=%b required 8 and 0110", got.size(), pv);
        end
    endtask

    task automatic test_isolation();
        run_stream(7, 0, 4, 100, 0, 1);
        run_stream(2, 1, 2, 33, 2, 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++)
            run_stream($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 3),
                       $urandom_range(0, 1023), 2, 0);
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        cols_cfg = 10'd7; rows_cfg = 10'd0; glen_cfg = 4'd4; stride_cfg = 10'd100;
        start = 1'b1; rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 50 && n < 5; cyc++) begin
            if (valid) n++;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dataout !== 13'h0 || n != 5) begin
            n_fail++;
            $display("FAIL reset_mid: n=%0d valid=%b busy=%b done=%b dataout=%h required 5,0,0,0,0",
                     n, valid, busy, done, dataout);
        end
        @(negedge clk);
        rst = 1'b0;
        run_stream(7, 0, 4, 100, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_multirow();
        test_isolation();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cnn_layer_accel_seq_gen.md
Name: cnn_layer_accel_seq_gen

Overview:
Hardware generator for the AWE sequence-word stream. It replaces the table that software or the bench currently builds and pushes through the seq_datain_tag/seq_datain_rdy port. It is parametrised in sequence-field width, column/row count widths and group length. Compared with the fixed 5-word, single-pass table, it adds a configurable group length, a configurable address stride, multi-row passes and backpressure stalling. It sits between the layer configuration registers and the datain mux of cnn_layer_accel_octo.

Parameters:
C_SEQ_WIDTH, 10, width of the SEQ field; output word width is C_SEQ_WIDTH+3
C_COL_WIDTH, 10, width of num_out_cols_cfg and the column counter
C_ROW_WIDTH, 10, width of num_out_rows_cfg and the row counter
C_GRP_WIDTH, 4, width of group_len_cfg and the word-in-group counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
num_out_cols_cfg  in  C_COL_WIDTH  output columns minus 1
num_out_rows_cfg  in  C_ROW_WIDTH  row passes minus 1
group_len_cfg  in  C_GRP_WIDTH  words per column group minus 1
seq_stride_cfg  in  C_SEQ_WIDTH  SEQ increment between words of a group
dataout  out  C_SEQ_WIDTH+3  word {RM, RST, P, SEQ}; RM is the MSB
dataout_valid  out  1  dataout holds a word
dataout_tag  out  1  equal to dataout_valid; drives seq_datain_tag
dataout_rdy  in  1  consumer accepts the word (seq_datain_rdy)
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (asynchronous): state IDLE; dataout, dataout_valid, dataout_tag, busy and done all 0; all counters 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start=1 at edge N:
  - all four cfg inputs are latched at edge N; cfg changes during RUN are ignored.
  - counters r=0, c=0, k=0; accumulator acc=0.
  - the first word is on dataout with dataout_valid=1 from edge N (visible in cycle N+1). Latency is 1 cycle.
- Word (r, c, k) fields:
  - SEQ = acc, where acc = c + k*stride mod 2^C_SEQ_WIDTH, built by accumulation. Overflow wraps silently.
  - RST = (k==0).
  - P = (k==0) ? (c[0] ^ r[0]) : 0.
  - RM = (k==group_len_cfg).
  - group_len_cfg=0 gives one word per group with RST=1 and RM=1.
- Handshake:
  - a word is transferred when dataout_valid and dataout_rdy are both high at a rising edge.
  - while dataout_valid=1 and dataout_rdy=0, dataout holds exactly and the counters freeze.
  - no bubbles: after each transfer the next word is presented in the following cycle.
- Counter advance on transfer:
  - if k<glen: k++, acc += stride.
  - else k=0. If c<cols: c++, acc=c+1. Else c=0, acc=0, and if r<rows then r++, otherwise this is the final word.
- Final transfer: RUN -> DONE. dataout_valid and dataout_tag drop at the same edge and dataout returns to 0. busy drops.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in RUN and DONE; it is accepted again from IDLE on the cycle after done.
- rst asserted mid-RUN aborts immediately to the reset values; a partially sent stream is not resumed.
- Total words = (rows+1)*(cols+1)*(glen+1).

Test Plan:
- Basic: cols=7, rows=0, glen=4, stride=100, rdy=1 -> 40 words. Column 0 is 0,100,200,300,400 with word0 RST=1, P=0 and word4 RM=1. Column 3 word0 is SEQ=3, P=1. done pulses 1 cycle after word 40; busy is high for 40 cycles.
- Backpressure: same config, rdy low for 3 cycles on word 7 (column 1, word 2, SEQ=201) -> word held stable for all 3 cycles, no duplicate or skipped word, still 40 transfers.
- Wrap and single-word groups:
  - stride=512, glen=4: column 0 SEQ is 0,512,0,512,0 (mod 1024).
  - glen=0, cols=3: 4 words, SEQ 0..3, each with RST=1 and RM=1.
- Multi-row: rows=1, cols=1, glen=1, stride=10 -> 8 words. Word0 P values across groups are 0,1,1,0.
- Config/start isolation: change cfg and pulse start mid-RUN -> output sequence unaffected, no restart.
- Reset mid-stream: rst after word 5 -> in the same cycle dataout_valid=0, busy=0, done=0. A new start then replays from word (0,0,0).
